// File: rtl/hex_scan_driver.sv
// -----------------------------------------------------------------------------
// hex_scan_driver
//
// Purpose:
//   Takes the processor core's HEX result bus and shows it on a multiplexed
//   seven-segment display, lighting one digit per scan slot. A loaded value
//   first goes into a pending register. It moves into the displayed (shadow)
//   register only at a frame boundary, so one frame never mixes old and new
//   digits. Leading-zero blanking is optional, and a one-cycle pulse marks
//   every frame boundary.
//
// Parameters:
//   DIGITS     : number of display digits; value width is 4*DIGITS
//   CLK_DIV    : clock cycles each digit stays lit (>= 2)
//   ACTIVE_LOW : 1 inverts seg_o/an_o/dp_o at the output registers
//
// Ports:
//   clk_i       in   1         system clock
//   rst_i       in   1         synchronous active-high reset
//   value_i     in   4*DIGITS  value to display; nibble k drives digit k
//   load_i      in   1         capture value_i this cycle
//   blank_lz_i  in   1         1 enables leading-zero blanking
//   seg_o       out  7         segments {g,f,e,d,c,b,a}
//   dp_o        out  1         decimal point, always inactive
//   an_o        out  DIGITS    one-hot digit enable
//   frame_o     out  1         one-cycle pulse after each frame boundary
//
// Every output is registered, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module hex_scan_driver #(
   parameter int DIGITS     = 8,
   parameter int CLK_DIV    = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic                  load_i,
   input  logic                  blank_lz_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Output polarity: XOR with this turns internal active-high values into
   // pin levels.
   localparam logic POL = (ACTIVE_LOW != 0);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] shadow;     // value currently being scanned out
   logic [4*DIGITS-1:0] pending;    // latest load, waiting for a boundary
   logic                pend_vld;

   logic                tick;
   logic                boundary;

   // Per-digit decode of the current scan slot
   logic [3:0]          nib;
   logic [DIGITS-1:0]   an_int;
   logic [DIGITS-1:0]   zero_above;  // bit k: nibbles k..DIGITS-1 all zero
   logic                cur_blank;
   logic [6:0]          seg_int;

   // ---------------------------------------------------------------------------
   // Seven-segment font, bit order {g,f,e,d,c,b,a}, active-high
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // Scan timing
   // ---------------------------------------------------------------------------
   assign tick     = (div_cnt == DIV_LAST);
   assign boundary = tick && (idx == IDX_LAST);

   // ---------------------------------------------------------------------------
   // Digit select and blanking for the slot addressed by idx
   // ---------------------------------------------------------------------------
   always_comb begin
      nib    = 4'h0;
      an_int = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nib       = shadow[4*k +: 4];
            an_int[k] = 1'b1;
         end
      end
   end

   // Shifting the whole shadow right by 4*k and testing for zero checks every
   // nibble at or above digit k in one compare. Each bit stands alone, so no
   // ripple chain forms across the vector.
   always_comb begin
      zero_above = '0;
      for (int k = 0; k < DIGITS; k++) begin
         zero_above[k] = ((shadow >> (4*k)) == '0);
      end
   end

   // Digit 0 is never blanked, so a value of zero still shows a single "0".
   always_comb begin
      cur_blank = blank_lz_i && (idx != '0) && zero_above[idx];
      seg_int   = cur_blank ? 7'h00 : font(nib);
   end

   // ---------------------------------------------------------------------------
   // Sequential logic: prescaler, scan index, load/shadow, output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt  <= '0;
         idx      <= '0;
         shadow   <= '0;
         pending  <= '0;
         pend_vld <= 1'b0;
         seg_o    <= {7{POL}};
         an_o     <= {DIGITS{POL}};
         dp_o     <= POL;
         frame_o  <= 1'b0;
      end else begin
         // Prescaler and digit index
         if (tick) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // A load on the boundary cycle itself goes straight to shadow. It
         // wins over any older pending value, and both paths leave nothing
         // pending.
         if (boundary) begin
            if (load_i) begin
               shadow <= value_i;
            end else if (pend_vld) begin
               shadow <= pending;
            end
            pend_vld <= 1'b0;
         end else if (load_i) begin
            pending  <= value_i;
            pend_vld <= 1'b1;
         end

         // Outputs: one cycle behind idx/shadow
         frame_o <= boundary;
         seg_o   <= seg_int ^ {7{POL}};
         an_o    <= an_int ^ {DIGITS{POL}};
         dp_o    <= POL;
      end
   end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Downstream consumer of the processor core's 32-bit HEX result bus.
- Drives a multiplexed 8-digit seven-segment display, one digit per scan slot.
- Holds the loaded value in a shadow register that changes only at frame boundaries, so a frame never mixes old and new digits.
- Optional leading-zero blanking and a frame-boundary pulse.

Parameters:
- DIGITS, 8: number of display digits; value width is 4*DIGITS.
- CLK_DIV, 50000: clock cycles each digit stays lit (must be >= 2).
- ACTIVE_LOW, 1: 1 inverts seg_o and an_o at the output registers; 0 means active-high.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- value_i  in  4*DIGITS  value to display; nibble k maps to digit k, with digit 0 as LSB.
- load_i  in  1  capture value_i this cycle.
- blank_lz_i  in  1  1 enables leading-zero blanking.
- seg_o  out  7  segments {g,f,e,d,c,b,a}.
- dp_o  out  1  decimal point, always inactive.
- an_o  out  DIGITS  one-hot digit enable.
- frame_o  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i); all state updates on the rising edge of clk_i.
- Reset state:
  - div_cnt=0, idx=0, shadow=0, pending=0, pend_vld=0.
  - Outputs seg_o, an_o and dp_o are all inactive (all 1 when ACTIVE_LOW=1); frame_o=0.
- Reset asserted mid-scan takes effect on that edge; any pending load is discarded.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (div_cnt==CLK_DIV-1).
  - On tick, idx advances by 1, wrapping DIGITS-1 -> 0.
- Frame boundary: tick with idx==DIGITS-1. frame_o=1 on the cycle after the boundary edge (registered), for exactly one cycle.
- Load handling:
  - load_i=1 writes pending<=value_i and pend_vld<=1. If several loads arrive before a boundary, the last one wins.
  - At a boundary edge with pend_vld=1: shadow<=pending, pend_vld<=0.
  - At a boundary edge with load_i=1 on that same cycle: shadow<=value_i directly (bypass), pend_vld<=0.
  - Without a boundary, shadow never changes.
- Output registers (one cycle latency from idx/shadow):
  - an_o(internal) = one-hot(idx).
  - nib = shadow[4*idx+3 : 4*idx].
  - seg(internal) = font(nib), unless the digit is blanked, in which case it is 0.
  - Blank rule: digit k is blanked iff blank_lz_i=1, k!=0, and all nibbles k..DIGITS-1 of shadow are 0. Digit 0 is never blanked; a blanked digit still has its anode enabled.
  - Polarity: outputs equal the internal values, inverted when ACTIVE_LOW=1.
- First cycle after reset release: outputs still at reset values. On the second edge they show digit 0 of shadow=0: seg internal 0x3F, an internal 0x01.
- Font (gfedcba, hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- No combinational path from any input to any output.
- div_cnt width is clog2(CLK_DIV); idx width is clog2(DIGITS).

Test Plan:
- Reset/scan, CLK_DIV=4, ACTIVE_LOW=0: release reset; value_i=0x12345678, load_i pulsed once.
  -> an_o steps 0x01,0x02,...,0x80 every 4 cycles.
  -> First frame shows all 0x3F; frame_o pulses.
  -> Next frame: digit0 seg=0x7F (8), digit7 seg=0x06 (1).
- Tear-free update: load 0xAAAAAAAA then 0x0000BEEF mid-frame.
  -> Remainder of the frame is unchanged.
  -> Next frame shows only BEEF: digit3 seg=0x7C, digit0 seg=0x71; 0xAAAAAAAA never appears.
- Boundary bypass: load_i=1 exactly on the boundary cycle with value 0x0000000F.
  -> Next frame shows digit0 seg=0x71 immediately; pend_vld=0 afterward.
- Leading-zero blanking: shadow=0x00000305, blank_lz_i=1.
  -> Digits 7..3 seg=0x00 with anodes still scanned; digit2 seg=0x4F, digit1 seg=0x3F, digit0 seg=0x6D.
  -> With shadow=0, digit0 seg=0x3F and all others blank.
- Polarity: ACTIVE_LOW=1, digit0 showing 0.
  -> seg_o=0x40, an_o=0xFE, dp_o=1.
  -> During reset seg_o=0x7F, an_o=0xFF.
- Reset mid-operation: assert rst_i with idx=5 and pend_vld=1.
  -> Next edge: outputs inactive, idx=0, shadow=0.
  -> After release the pending value is never displayed.
